rtype_issue_ctrl: RTL

Multi-cycle issue controller for RV32I R-type instructions. It accepts one instruction word per handshake and decodes opcode, funct3 and funct7 into the 4-bit ALU select. It reads both source registers, drives the combinational ALU operands, captures the ALU result and issues a single-cycle register-file write-back. It sits between the fetch stage and the ALU/register-file pair, and is the driver of the ALU `ALU_sel`/`reg1`/`reg2` inputs.

---
 rtl/rtype_pkg.sv | 38 +++
 rtl/rtype_decoder.sv | 41 ++++
 rtl/rtype_issue_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/rtype_pkg.sv
// Shared types for the RV32I R-type issue controller.
// Opcode/funct7 constants, ALU select map, FSM states, decode bundle.
package rtype_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE  = 7'h00;
    localparam logic [6:0] F7_ALT   = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_sel_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB
    } issue_state_e;

    typedef struct packed {
        logic       legal;
        alu_sel_e   alu_sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_t;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: instruction word to legality,
// ALU select and register indices.
module rtype_decoder
    import rtype_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       alt;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign alt    = (f7 == F7_ALT);

    always_comb begin
        dec     = '0;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rd  = instr[11:7];
        // funct7=0x20 only selects SUB and SRA
        dec.legal = (opcode == OP_RTYPE) &&
                    ((f7 == F7_BASE) ||
                     (alt && (f3 == 3'b000 || f3 == 3'b101)));
        unique case (f3)
            3'b000: dec.alu_sel = alt ? ALU_SUB : ALU_ADD;
            3'b001: dec.alu_sel = ALU_SLL;
            3'b010: dec.alu_sel = ALU_SLT;
            3'b011: dec.alu_sel = ALU_SLTU;
            3'b100: dec.alu_sel = ALU_XOR;
            3'b101: dec.alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110: dec.alu_sel = ALU_OR;
            3'b111: dec.alu_sel = ALU_AND;
        endcase
    end

endmodule

// File: rtl/rtype_issue_ctrl.sv
// Five-state R-type issue controller (IDLE/DECODE/READ/EXEC/WB).
// Optional retire counter: define RTYPE_RETIRE_CNT_EN.
module rtype_issue_ctrl
    import rtype_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instr,
    output logic [RADDR_W-1:0] rs1_addr,
    output logic [RADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    output logic [3:0]         ALU_sel,
    output logic [XLEN-1:0]    reg1,
    output logic [XLEN-1:0]    reg2,
    input  logic [XLEN-1:0]    ALU_Out,
    output logic               wb_en,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]    wb_data,
    output logic               illegal,
    output logic [31:0]        retire_cnt
);

    issue_state_e       state_q, state_d;
    logic [31:0]        instr_q;
    dec_t               dec;
    logic [RADDR_W-1:0] rs1_q, rs2_q, rd_q;
    alu_sel_e           sel_q;
    logic [XLEN-1:0]    reg1_q, reg2_q, wb_data_q;

    rtype_decoder u_dec (
        .instr (instr_q),
        .dec   (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (instr_valid) state_d = S_DECODE;
            S_DECODE: state_d = dec.legal ? S_READ : S_IDLE;
            S_READ:   state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            sel_q     <= ALU_ADD;
            reg1_q    <= '0;
            reg2_q    <= '0;
            wb_data_q <= '0;
        end else begin
            if (state_q == S_IDLE && instr_valid)
                instr_q <= instr;
            if (state_q == S_DECODE && dec.legal) begin
                rs1_q <= RADDR_W'(dec.rs1);
                rs2_q <= RADDR_W'(dec.rs2);
                rd_q  <= RADDR_W'(dec.rd);
                sel_q <= dec.alu_sel;
            end
            if (state_q == S_READ) begin
                reg1_q <= rs1_data;
                reg2_q <= rs2_data;
            end
            if (state_q == S_EXEC)
                wb_data_q <= ALU_Out;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign illegal     = (state_q == S_DECODE) && !dec.legal;
    // x0 writes are suppressed but still retire
    assign wb_en       = (state_q == S_WB) && (rd_q != '0);
    assign rs1_addr    = rs1_q;
    assign rs2_addr    = rs2_q;
    assign ALU_sel     = sel_q;
    assign reg1        = reg1_q;
    assign reg2        = reg2_q;
    assign wb_addr     = rd_q;
    assign wb_data     = wb_data_q;

`ifdef RTYPE_RETIRE_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt_q <= '0;
        else if (state_q == S_WB)  cnt_q <= cnt_q + 32'd1;
    end

    assign retire_cnt = cnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule
